// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with valid/ready load and paced shifting
module piso_tx #(
  parameter int bits      = 8,
  parameter bit msb_first = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] d_in,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic            shift_en,
  output logic            s_out,
  output logic            s_valid,
  output logic            s_last,
  output logic            done
);
  localparam int CW = $clog2(bits);
  localparam logic [CW-1:0] LAST = CW'(bits - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [bits-1:0] sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            s_out_q, s_out_d;
  logic            s_valid_q, s_valid_d;
  logic            s_last_q, s_last_d;
  logic            done_q, done_d;
  logic            consume, accept;

  // Next-state: a new word may be taken on the same edge that consumes the final bit,
  // so back-to-back words stream without a gap.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    load_ready = state_q == IDLE || (shift_en && cnt_q == LAST);
    consume    = state_q == SHIFT && shift_en && cnt_q == LAST;
    accept     = load_valid && load_ready;
    if (accept) begin
      state_d = SHIFT;
      sr_d    = d_in;
      cnt_d   = '0;
    end else if (consume) begin
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = '0;
    end else if (state_q == SHIFT && shift_en) begin
      sr_d  = msb_first ? {sr_q[bits-2:0], 1'b0} : {1'b0, sr_q[bits-1:1]};
      cnt_d = cnt_q + 1'b1;
    end
    s_out_d   = state_d == SHIFT && (msb_first ? sr_d[bits-1] : sr_d[0]);
    s_valid_d = state_d == SHIFT;
    s_last_d  = state_d == SHIFT && cnt_d == LAST;
    done_d    = consume;
  end

  // State and registered outputs; reset aborts any word in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      s_out_q   <= 1'b0;
      s_valid_q <= 1'b0;
      s_last_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      s_out_q   <= s_out_d;
      s_valid_q <= s_valid_d;
      s_last_q  <= s_last_d;
      done_q    <= done_d;
    end
  end

  assign s_out   = s_out_q;
  assign s_valid = s_valid_q;
  assign s_last  = s_last_q;
  assign done    = done_q;
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: randomized and directed checks of piso_tx (MSB- and LSB-first) against a word/bit-index model
module tb_piso_tx;
  localparam int B = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [B-1:0] d   = '0;
  logic         lv  = 1'b0;
  logic         se  = 1'b0;
  logic         rdy_m, so_m, sv_m, sl_m, dn_m;
  logic         rdy_l, so_l, sv_l, sl_l, dn_l;

  int checks = 0;
  int errors = 0;

  logic [B-1:0] m_word = '0;
  int           m_k    = 0;
  bit           m_act  = 0;
  bit           m_done = 0;

  always #5 clk = ~clk;

  piso_tx #(.bits(B), .msb_first(1)) u_m (
    .clk(clk), .rst(rst), .d_in(d), .load_valid(lv), .load_ready(rdy_m),
    .shift_en(se), .s_out(so_m), .s_valid(sv_m), .s_last(sl_m), .done(dn_m)
  );

  piso_tx #(.bits(B), .msb_first(0)) u_l (
    .clk(clk), .rst(rst), .d_in(d), .load_valid(lv), .load_ready(rdy_l),
    .shift_en(se), .s_out(so_l), .s_valid(sv_l), .s_last(sl_l), .done(dn_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_out();
    chk("s_out_msb", so_m, m_act ? m_word[B-1-m_k] : 1'b0);
    chk("s_out_lsb", so_l, m_act ? m_word[m_k] : 1'b0);
    chk("s_valid_msb", sv_m, m_act);
    chk("s_valid_lsb", sv_l, m_act);
    chk("s_last", {sl_m, sl_l}, {2{m_act && m_k == B-1}});
    chk("done", {dn_m, dn_l}, {2{m_done}});
  endtask

  task automatic step(input logic r, input logic l, input logic [B-1:0] dd, input logic s);
    bit fin, ok;
    @(negedge clk);
    rst = r; lv = l; d = dd; se = s;
    #1;
    ok = !m_act || (s && m_k == B-1);
    if (!r) chk("load_ready", {rdy_m, rdy_l}, {2{ok}});
    @(posedge clk);
    if (r) begin
      m_act = 0; m_k = 0; m_done = 0;
    end else begin
      fin    = m_act && s && m_k == B-1;
      m_done = fin;
      if (l && ok) begin
        m_word = dd; m_k = 0; m_act = 1;
      end else if (fin) begin
        m_act = 0; m_k = 0;
      end else if (m_act && s) m_k++;
    end
    #1;
    check_out();
  endtask

  initial begin
    logic [B-1:0] acc_m, acc_l;
    logic [15:0]  acc16;
    bit           vall;
    int           dcnt;
    #2;
    chk("reset_outs", {rdy_m, so_m, sv_m, sl_m, dn_m, so_l, sv_l}, 7'b1000000);
    step(0, 0, '0, 1);
    // 25 with constant shift_en
    step(0, 1, 8'd25, 1);
    for (int i = 0; i < B; i++) begin
      acc_m = {acc_m[B-2:0], so_m};
      acc_l = {acc_l[B-2:0], so_l};
      step(0, 0, '0, 1);
    end
    chk("seq25_msb", acc_m, 8'b00011001);
    chk("seq25_lsb", acc_l, 8'b10011000);
    chk("done25", dn_m, 1);
    step(0, 0, '0, 1);
    chk("idle_after25", {sv_m, dn_m}, 2'b00);
    // A5 with shift_en toggling
    step(0, 1, 8'hA5, 1);
    dcnt = 0;
    acc_m = '0;
    for (int i = 0; i < 2 * B; i++) begin
      if (i[0] == 1'b0) acc_m = {acc_m[B-2:0], so_m};
      step(0, 0, '0, i[0]);
      dcnt += int'(dn_m);
    end
    chk("seqA5", acc_m, 8'hA5);
    chk("doneA5_count", dcnt, 1);
    // back-to-back F0 then 0F with load_valid held
    step(0, 1, 8'hF0, 1);
    dcnt = 0; vall = 1;
    for (int i = 0; i < 2 * B; i++) begin
      acc16 = {acc16[14:0], so_m};
      vall &= sv_m;
      step(0, i < B, 8'h0F, 1);
      dcnt += int'(dn_m);
    end
    chk("seqF00F", acc16, 16'hF00F);
    chk("valid_contig", vall, 1);
    chk("done_b2b_count", dcnt, 2);
    // async reset mid-word of FF
    step(0, 1, 8'hFF, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("async_rst", {so_m, sv_m, sl_m, dn_m, so_l, sv_l}, 6'b0);
    m_act = 0; m_k = 0; m_done = 0;
    step(1, 1, 8'h55, 1);
    step(0, 0, '0, 1);
    chk("no_done_after_rst", dn_m, 0);
    step(0, 1, 8'h81, 1);
    for (int i = 0; i < B; i++) begin
      acc_m = {acc_m[B-2:0], so_m};
      step(0, 0, '0, 1);
    end
    chk("seq81", acc_m, 8'h81);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(63) == 0, $urandom_range(3) != 0, B'($urandom), $urandom_range(3) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end
endmodule
